// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - two-master arbiter for the single ROM port (fetch vs RIB)
module rom_port_arbiter #(
  parameter int ROM_DEPTH = 4096,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        rom_we_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] rom_data_o,
  input  logic [31:0] rom_data_i,
  output logic        hold_flag_o
);

  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [3:0]  BURST_MAX = 4'(MAX_BURST);
  localparam logic [29:0] DEPTH     = 30'(ROM_DEPTH);

  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

  state_t     state;
  logic [3:0] burst_cnt;
  logic       m0_win;
  logic       m0_in_range;
  logic       m1_in_range;

  assign m0_in_range = (m0_addr_i[31:2] < DEPTH);
  assign m1_in_range = (m1_addr_i[31:2] < DEPTH);

  // M1 wins unless it is idle or has used up its burst allowance while M0 waits
  assign m0_win   = m0_req_i & (~m1_req_i | (burst_cnt == BURST_MAX));
  assign m0_gnt_o = rst & m0_win;
  assign m1_gnt_o = rst & m1_req_i & ~m0_win;

  assign hold_flag_o = m0_req_i & ~m0_gnt_o;

  always_comb begin
    rom_addr_o = ZERO_WORD;
    rom_data_o = ZERO_WORD;
    if (m0_gnt_o) begin
      rom_addr_o = m0_addr_i;
    end else if (m1_gnt_o) begin
      rom_addr_o = m1_addr_i;
      rom_data_o = m1_wdata_i;
    end
  end

  assign rom_we_o = m1_gnt_o & m1_we_i & m1_in_range;

  // state holds the owner of the transfer accepted at the last edge, i.e. whose response is out now
  assign m0_rvalid_o = (state == OWN_M0);
  assign m1_rvalid_o = (state == OWN_M1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      burst_cnt  <= 4'd0;
      m0_rdata_o <= ZERO_WORD;
      m1_rdata_o <= ZERO_WORD;
    end else begin
      if (m0_gnt_o) begin
        state <= OWN_M0;
      end else if (m1_gnt_o) begin
        state <= OWN_M1;
      end else begin
        state <= IDLE;
      end

      if (!m0_req_i || m0_gnt_o) begin
        burst_cnt <= 4'd0;
      end else if (m1_gnt_o && (burst_cnt != BURST_MAX)) begin
        burst_cnt <= burst_cnt + 4'd1;
      end

      if (m0_gnt_o) begin
        m0_rdata_o <= m0_in_range ? rom_data_i : ZERO_WORD;
      end
      if (m1_gnt_o) begin
        m1_rdata_o <= (m1_we_i || !m1_in_range) ? ZERO_WORD : rom_data_i;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - scoreboard bench for rom_port_arbiter
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m1_wdata_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        rom_we_o, hold_flag_o;
  logic [31:0] rom_addr_o, rom_data_o, rom_data_i;

  logic [31:0] mem [0:4095];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  rom_port_arbiter #(.ROM_DEPTH(4096), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .rom_we_o(rom_we_o), .rom_addr_o(rom_addr_o), .rom_data_o(rom_data_o),
    .rom_data_i(rom_data_i), .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // out-of-range words read as a poison value so the DUT must zero them itself
  assign rom_data_i = (rom_addr_o[31:2] < 30'd4096) ? mem[rom_addr_o[13:2]] : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic m0r, input logic [31:0] m0a,
                       input logic m1r, input logic m1we, input logic [31:0] m1a,
                       input logic [31:0] m1wd);
    @(posedge clk);
    #1;
    rst = r; m0_req_i = m0r; m0_addr_i = m0a;
    m1_req_i = m1r; m1_we_i = m1we; m1_addr_i = m1a; m1_wdata_i = m1wd;
    #3;
  endtask

  task automatic chk_gnt(input string name, input logic g0, input logic g1, input logic hold);
    chk({name, "_m0_gnt"}, {31'd0, m0_gnt_o}, {31'd0, g0});
    chk({name, "_m1_gnt"}, {31'd0, m1_gnt_o}, {31'd0, g1});
    chk({name, "_hold"}, {31'd0, hold_flag_o}, {31'd0, hold});
  endtask

  task automatic push0(input logic [31:0] d);
    exp_t e;
    e.data = d; e.cyc = cyc + 1;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [31:0] d);
    exp_t e;
    e.data = d; e.cyc = cyc + 1;
    q1.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA5000000 | 32'(i);
    mem[4] = 32'hDEADBEEF;
    rst = 1'b0; m0_req_i = 1'b1; m0_addr_i = 32'h10;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h40; m1_wdata_i = 32'h0;

    fork
      forever begin
        @(posedge clk);
        if (rom_we_o === 1'b1) mem[rom_addr_o[13:2]] = rom_data_o;
      end
      forever begin
        exp_t e;
        @(negedge clk);
        if (m0_rvalid_o === 1'b1) begin
          if (q0.size() == 0) chk("m0_unexpected_rvalid", 32'd1, 32'd0);
          else begin
            e = q0.pop_front();
            chk("m0_rdata", m0_rdata_o, e.data);
            chk("m0_latency", 32'(cyc), 32'(e.cyc));
          end
        end
        if (m1_rvalid_o === 1'b1) begin
          if (q1.size() == 0) chk("m1_unexpected_rvalid", 32'd1, 32'd0);
          else begin
            e = q1.pop_front();
            chk("m1_rdata", m1_rdata_o, e.data);
            chk("m1_latency", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    join_none

    // reset held with both masters requesting
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
      chk_gnt("reset", 1'b0, 1'b0, 1'b1);
      chk("reset_m0_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
      chk("reset_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
      chk("reset_m0_rdata", m0_rdata_o, 32'd0);
      chk("reset_m1_rdata", m1_rdata_o, 32'd0);
      chk("reset_rom_we", {31'd0, rom_we_o}, 32'd0);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_gnt("idle", 1'b0, 1'b0, 1'b0);
    chk("idle_rom_addr", rom_addr_o, 32'h0);

    // single fetch
    drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_gnt("fetch", 1'b1, 1'b0, 1'b0);
    chk("fetch_rom_addr", rom_addr_o, 32'h10);
    push0(32'hDEADBEEF);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // contention: M1 x4 then M0, repeating
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
      if ((i % 5) < 4) begin
        chk_gnt("contend", 1'b0, 1'b1, 1'b1);
        push1(32'hA5000010);
      end else begin
        chk_gnt("contend", 1'b1, 1'b0, 1'b0);
        push0(32'hDEADBEEF);
      end
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // write then read of the same word
    drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'h12345678);
    chk_gnt("wr", 1'b0, 1'b1, 1'b1);
    chk("wr_rom_we", {31'd0, rom_we_o}, 32'd1);
    push1(32'h0);
    drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_gnt("rd_after_wr", 1'b1, 1'b0, 1'b0);
    push0(32'h12345678);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // out-of-range write then read at ROM_DEPTH*4
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4000, 32'h55);
    chk_gnt("oor_wr", 1'b0, 1'b1, 1'b0);
    chk("oor_wr_rom_we", {31'd0, rom_we_o}, 32'd0);
    push1(32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4000, 32'h0);
    chk_gnt("oor_rd", 1'b0, 1'b1, 1'b0);
    push1(32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("oor_word0_intact", mem[0], 32'hA5000000);

    // reset in the middle of an M1 burst
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h44, 32'h0);
      chk_gnt("preburst", 1'b0, 1'b1, 1'b1);
      push1(32'hA5000011);
    end
    drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h44, 32'h0);
    chk_gnt("midreset", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h44, 32'h0);
      if (i < 4) begin
        chk_gnt("postreset", 1'b0, 1'b1, 1'b1);
        push1(32'hA5000011);
      end else begin
        chk_gnt("postreset", 1'b1, 1'b0, 1'b0);
        push0(32'hDEADBEEF);
      end
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #4;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
